ring_counter_gen: RTL and testbench

Parametrised ring/Johnson counter, the general-purpose successor to the team's fixed 3-bit ring counter. It provides a configurable width, run-time ring or Johnson (twisted-ring) mode, shift direction, enable, parallel load, a wrap pulse, and illegal-state detection with optional self-correction. It is intended as a one-hot/Johnson sequencer for phase and strobe generation in datapath control.

---
 rtl/ring_counter_gen.sv | 88 ++++++++
 tb/tb_ring_counter_gen.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/ring_counter_gen.sv
// Parametrised ring / Johnson sequencer with wrap pulse, sticky illegal-state
// flag and optional self-correction back to the home state.
module ring_counter_gen #(
    parameter int WIDTH        = 4,
    parameter bit SELF_CORRECT = 1'b1
) (
    input  logic             clk,
    input  logic             mrst,
    input  logic             en,
    input  logic             mode,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             wrap,
    output logic             fault
);

    localparam logic [WIDTH-1:0] RING_HOME = WIDTH'(1);
    localparam logic [WIDTH-1:0] JOHN_HOME = '0;

    function automatic logic [WIDTH-1:0] home_of(input logic m);
        return m ? JOHN_HOME : RING_HOME;
    endfunction

    // Johnson legality counts adjacent-bit transitions; wrap-around is ignored.
    function automatic logic is_legal(input logic [WIDTH-1:0] s, input logic m);
        logic [WIDTH-2:0] trans;
        trans = s[WIDTH-1:1] ^ s[WIDTH-2:0];
        if (m)
            return (trans & (trans - (WIDTH-1)'(1))) == '0;
        else
            return (s != '0) && ((s & (s - WIDTH'(1))) == '0);
    endfunction

    function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] s,
                                                    input logic m,
                                                    input logic d);
        logic fb;
        if (d) begin
            fb = m ? ~s[0] : s[0];
            return {fb, s[WIDTH-1:1]};
        end else begin
            fb = m ? ~s[WIDTH-1] : s[WIDTH-1];
            return {s[WIDTH-2:0], fb};
        end
    endfunction

    logic             legal;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] q_nxt;
    logic             wrap_nxt;
    logic             fault_nxt;

    always_comb begin
        legal     = is_legal(q, mode);
        shifted   = shift_step(q, mode, dir);
        q_nxt     = q;
        wrap_nxt  = 1'b0;
        fault_nxt = fault | ~legal;
        if (load) begin
            q_nxt     = load_val;
            fault_nxt = 1'b0;
        end else if (en) begin
            if (legal) begin
                q_nxt    = shifted;
                wrap_nxt = (shifted == home_of(mode));
            end else if (SELF_CORRECT) begin
                q_nxt = home_of(mode);
            end else begin
                q_nxt = shifted;
            end
        end
    end

    always_ff @(posedge clk or posedge mrst) begin
        if (mrst) begin
            q     <= RING_HOME;
            wrap  <= 1'b0;
            fault <= 1'b0;
        end else begin
            q     <= q_nxt;
            wrap  <= wrap_nxt;
            fault <= fault_nxt;
        end
    end

endmodule

// File: tb/tb_ring_counter_gen.sv
// Directed bench for ring_counter_gen: one self-correcting and one flag-only
// instance driven from the same stimulus.
module tb_ring_counter_gen;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         mrst;
    logic         en;
    logic         mode;
    logic         dir;
    logic         load;
    logic [W-1:0] load_val;
    logic [W-1:0] q_sc, q_nc;
    logic         wrap_sc, wrap_nc;
    logic         fault_sc, fault_nc;

    int n_chk  = 0;
    int n_pass = 0;

    ring_counter_gen #(.WIDTH(W), .SELF_CORRECT(1'b1)) dut_sc (
        .clk(clk), .mrst(mrst), .en(en), .mode(mode), .dir(dir),
        .load(load), .load_val(load_val),
        .q(q_sc), .wrap(wrap_sc), .fault(fault_sc)
    );

    ring_counter_gen #(.WIDTH(W), .SELF_CORRECT(1'b0)) dut_nc (
        .clk(clk), .mrst(mrst), .en(en), .mode(mode), .dir(dir),
        .load(load), .load_val(load_val),
        .q(q_nc), .wrap(wrap_nc), .fault(fault_nc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [W-1:0] ring_exp [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [W-1:0] john_exp [9] = '{4'b0000, 4'b1000, 4'b1100, 4'b1110, 4'b1111,
                                   4'b0111, 4'b0011, 4'b0001, 4'b0000};

    initial begin
        mrst = 1'b1; en = 1'b0; mode = 1'b0; dir = 1'b0; load = 1'b0; load_val = '0;
        #3;
        chk("rst_q", q_sc, 4'b0001);
        chk("rst_wrap", wrap_sc, 1'b0);
        chk("rst_fault", fault_sc, 1'b0);
        tick();

        // ring, dir 0
        mrst = 1'b0; en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("ring_q%0d", i), q_sc, ring_exp[i]);
            chk($sformatf("ring_wrap%0d", i), wrap_sc, (i == 3));
            chk($sformatf("ring_fault%0d", i), fault_sc, 1'b0);
        end

        // Johnson, dir 1, from reset
        mrst = 1'b1;
        #1;
        chk("j_rst_q", q_sc, 4'b0001);
        chk("j_rst_wrap", wrap_sc, 1'b0);
        mrst = 1'b0; mode = 1'b1; dir = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            chk($sformatf("john_q%0d", i), q_sc, john_exp[i]);
            chk($sformatf("john_wrap%0d", i), wrap_sc, (i == 0 || i == 8));
            chk($sformatf("john_fault%0d", i), fault_sc, 1'b0);
        end

        // illegal load, ring dir 0
        mode = 1'b0; dir = 1'b0; en = 1'b0; load = 1'b1; load_val = 4'b0110;
        tick();
        chk("ill_load_q", q_sc, 4'b0110);
        chk("ill_load_fault", fault_sc, 1'b0);
        load = 1'b0; en = 1'b1;
        tick();
        chk("sc_q", q_sc, 4'b0001);
        chk("sc_fault", fault_sc, 1'b1);
        chk("sc_wrap", wrap_sc, 1'b0);
        chk("nc_q", q_nc, 4'b1100);
        chk("nc_fault", fault_nc, 1'b1);
        chk("nc_wrap", wrap_nc, 1'b0);
        en = 1'b0;
        tick();
        chk("sc_fault_sticky", fault_sc, 1'b1);
        chk("sc_hold_q", q_sc, 4'b0001);

        // load clears fault; hold for 3 cycles
        load = 1'b1; load_val = 4'b0100;
        tick();
        chk("clr_fault", fault_sc, 1'b0);
        load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("hold_q%0d", i), q_sc, 4'b0100);
            chk($sformatf("hold_wrap%0d", i), wrap_sc, 1'b0);
        end

        // load wins over en
        load = 1'b1; en = 1'b1; load_val = 4'b1000;
        tick();
        chk("prio_q", q_sc, 4'b1000);
        chk("prio_wrap", wrap_sc, 1'b0);

        // ring dir 1 wraps from 0010
        load_val = 4'b0010;
        tick();
        load = 1'b0; dir = 1'b1;
        tick();
        chk("rdir1_q", q_sc, 4'b0001);
        chk("rdir1_wrap", wrap_sc, 1'b1);

        // async reset between edges drops the wrap pulse
        mrst = 1'b1;
        #1;
        chk("async_q", q_sc, 4'b0001);
        chk("async_wrap", wrap_sc, 1'b0);
        mrst = 1'b0; en = 1'b0; dir = 1'b0;

        // mode switch: 0100 ring -> Johnson is illegal
        load = 1'b1; load_val = 4'b0100;
        tick();
        load = 1'b0; mode = 1'b1; en = 1'b1;
        tick();
        chk("ms1_q", q_sc, 4'b0000);
        chk("ms1_fault", fault_sc, 1'b1);
        chk("ms1_wrap", wrap_sc, 1'b0);
        chk("ms1_nc_q", q_nc, 4'b1001);

        // mode switch: 1000 ring -> Johnson is a legal step onto home
        mode = 1'b0; load = 1'b1; load_val = 4'b1000;
        tick();
        load = 1'b0; mode = 1'b1; en = 1'b1;
        tick();
        chk("ms2_q", q_sc, 4'b0000);
        chk("ms2_wrap", wrap_sc, 1'b1);
        chk("ms2_fault", fault_sc, 1'b0);
        en = 1'b0;
        tick();
        chk("ms2_wrap_one", wrap_sc, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
